muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DataWidth, default 32, operand and result width in bits (even, >= 8).
REQ-002 SHALL have port clk_i, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port valid_i, input, 1, request valid.
REQ-005 SHALL have port ready_o, output, 1, unit can accept a request.
REQ-006 SHALL have port src1_i, input, DataWidth, rs1 operand (dividend / multiplicand).
REQ-007 SHALL have port src2_i, input, DataWidth, rs2 operand (divisor / multiplier).
REQ-008 SHALL have port op_i, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port valid_o, output, 1, result valid.
REQ-010 SHALL have port ready_i, input, 1, consumer accepts result.
REQ-011 SHALL have port result_o, output, DataWidth, operation result.
REQ-012 SHALL have port err_o, output, 1, qualified by valid_o; op not supported in this build.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; ready_o = (state == IDLE).
REQ-014 SHALL accept a request on a rising edge with valid_i && ready_o, registering operands and op; inputs are ignored in every other state.
REQ-015 SHALL, on acceptance, take operand magnitudes per op signedness (MULH, DIV, REM: both signed; MULHSU: src1 signed only; others unsigned) and record the result sign.
REQ-016 SHALL run CALC for exactly DataWidth cycles: radix-2 shift-add multiply into a 2*DataWidth product, or radix-2 restoring divide, one bit per cycle from a down-counter.
REQ-017 SHALL enter DONE, applying sign correction, so valid_o rises exactly DataWidth+1 rising edges after the accepting edge.
REQ-018 SHALL return product[DataWidth-1:0] for MUL and product[2*DataWidth-1:DataWidth] for MULH/MULHSU/MULHU.
REQ-019 SHALL treat divisor zero as a fast path (IDLE -> DONE, valid_o one edge after acceptance): quotient all ones, remainder = src1.
REQ-020 SHALL treat signed overflow (DIV/REM of most-negative value by -1) as a fast path: quotient = most-negative value, remainder 0.
REQ-021 SHALL, in DONE, hold valid_o, result_o and err_o stable until ready_i is high on an edge, then return to IDLE; ready_i is ignored outside DONE.
REQ-022 SHALL not accept a new request in the cycle a result is consumed; the earliest next acceptance is the following edge.
REQ-023 SHALL drive result_o to 0 and err_o to 0 whenever valid_o is low.

Reset
REQ-024 SHALL, with rst_i high on an edge in any state (including mid-CALC), enter IDLE, discard the operation, clear counter and datapath registers, and drive ready_o=1 on the next cycle, valid_o=0, result_o=0, err_o=0.
REQ-025 SHALL give rst_i priority over a simultaneous valid_i or ready_i.

Configuration
REQ-026 SHALL, with macro MULDIV_DIV_EN defined, implement DIV, DIVU, REM, REMU per REQ-016 to REQ-020.
REQ-027 SHALL, with MULDIV_DIV_EN undefined, omit divider logic; ops 1xx go IDLE -> DONE in one edge with result_o=0 and err_o=1; multiply is unchanged.

Structure
REQ-028 SHALL place the muldiv_op_e op enum, the state enum and the funct3 constants in shared package muldiv_pkg.
REQ-029 SHALL use one sub-module, cond_negate (DataWidth-parametrised conditional two's complement), for operand magnitude and result sign correction.

Verification
REQ-030 SHALL cover: MUL 7 x -3 (DataWidth=32) -> result_o=0xFFFFFFEB, valid_o 33 edges after acceptance.
REQ-031 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF one edge after acceptance; DIV 0x80000000 / -1 -> 0x80000000.
REQ-033 SHALL cover: ready_i held low 5 cycles in DONE -> result held stable, ready_o=0, valid_i ignored; ready_i high -> IDLE next edge.
REQ-034 SHALL cover: rst_i pulsed at CALC cycle 10 -> IDLE, valid_o never asserted, and a new MUL 3 x 4 returns 12.
REQ-035 SHALL cover: build without MULDIV_DIV_EN, DIVU 9 / 3 -> valid_o after one edge, err_o=1, result_o=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state enums and RV32M funct3 constants for muldiv_unit.
package muldiv_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [2:0] {
        OP_MUL    = F3_MUL,
        OP_MULH   = F3_MULH,
        OP_MULHSU = F3_MULHSU,
        OP_MULHU  = F3_MULHU,
        OP_DIV    = F3_DIV,
        OP_DIVU   = F3_DIVU,
        OP_REM    = F3_REM,
        OP_REMU   = F3_REMU
    } muldiv_op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: two's complement of data when neg is set, pass-through otherwise.
module cond_negate #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] data,
    input  logic             neg,
    output logic [Width-1:0] result
);
    assign result = neg ? -data : data;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Divider present only when MULDIV_DIV_EN is defined; otherwise div ops return err_o.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] src1_i,
    input  logic [DataWidth-1:0] src2_i,
    input  logic [2:0]           op_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic                 err_o
);
    localparam int W  = DataWidth;
    localparam int CW = $clog2(DataWidth);

    muldiv_state_e  state;
    muldiv_op_e     op, op_q;
    logic [2:0]     opq_b;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] prod_q, step, fin_sel, fin_c;
    logic [W-1:0]   mcand_q, res_q, mag1, mag2, res;
    logic [W:0]     sum;
    logic           neg_q, err_q, sign1, sign2, a_neg, b_neg, is_div, neg_in;

    assign op     = muldiv_op_e'(op_i);
    assign opq_b  = op_q;
    assign is_div = op_i[2];
    assign sign1  = op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
    assign sign2  = op == OP_MULH || op == OP_DIV || op == OP_REM;
    assign a_neg  = sign1 & src1_i[W-1];
    assign b_neg  = sign2 & src2_i[W-1];
    // Remainder takes the dividend's sign; products and quotients the xor.
    assign neg_in = (is_div && op_i[1]) ? a_neg : a_neg ^ b_neg;

    cond_negate #(.Width(W)) u_mag1 (.data(src1_i), .neg(a_neg), .result(mag1));
    cond_negate #(.Width(W)) u_mag2 (.data(src2_i), .neg(b_neg), .result(mag2));

    assign sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MULDIV_DIV_EN
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};
    logic [W:0] rsh, diff;
    assign rsh  = {prod_q[2*W-1:W], prod_q[W-1]};
    assign diff = rsh - {1'b0, mcand_q};
    // Remainder lives in the high half, quotient bits shift into the low half.
    assign step = !opq_b[2] ? {sum, prod_q[W-1:1]} :
                  diff[W]   ? {rsh[W-1:0], prod_q[W-2:0], 1'b0} :
                              {diff[W-1:0], prod_q[W-2:0], 1'b1};
`else
    assign step = {sum, prod_q[W-1:1]};
`endif
    assign fin_sel = opq_b[2] ? {{W{1'b0}}, opq_b[1] ? step[2*W-1:W] : step[W-1:0]} : step;

    cond_negate #(.Width(2*W)) u_fix (.data(fin_sel), .neg(neg_q), .result(fin_c));

    assign res      = (op_q == OP_MUL || opq_b[2]) ? fin_c[W-1:0] : fin_c[2*W-1:W];
    assign ready_o  = state == IDLE;
    assign valid_o  = state == DONE;
    assign result_o = valid_o ? res_q : '0;
    assign err_o    = valid_o & err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    op_q    <= op;
                    neg_q   <= neg_in;
                    cnt_q   <= CW'(W - 1);
                    err_q   <= 1'b0;
                    res_q   <= '0;
                    prod_q  <= {{W{1'b0}}, is_div ? mag1 : mag2};
                    mcand_q <= is_div ? mag2 : mag1;
`ifdef MULDIV_DIV_EN
                    if (is_div && src2_i == '0) begin
                        state <= DONE;
                        res_q <= op_i[1] ? src1_i : '1;
                    end else if (is_div && sign1 && src1_i == MinVal && src2_i == '1) begin
                        state <= DONE;
                        res_q <= op_i[1] ? '0 : MinVal;
                    end else begin
                        state <= CALC;
                    end
`else
                    if (is_div) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
`endif
                end
                CALC: begin
                    prod_q <= step;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state <= DONE;
                        res_q <= res;
                    end
                end
                DONE: if (ready_i) begin
                    state <= IDLE;
                    res_q <= '0;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at DataWidth=32, both MULDIV_DIV_EN builds.
module tb_muldiv_unit;
    logic        clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
    logic [31:0] src1_i = '0, src2_i = '0;
    logic [2:0]  op_i = '0;
    logic        ready_o, valid_o, err_o;
    logic [31:0] result_o;
    int          pass_cnt = 0, total = 0;
    logic [31:0] r;
    logic        e;
    int          n;

    muldiv_unit #(.DataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .src1_i(src1_i), .src2_i(src2_i), .op_i(op_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request and return result/err plus edges from acceptance (inclusive) to valid_o.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic err, output int edges);
        @(negedge clk_i);
        valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        edges = 1;
        @(negedge clk_i);
        while (!valid_o && edges < 100) begin
            @(posedge clk_i);
            edges++;
            @(negedge clk_i);
        end
        if (!valid_o) check("timeout", 64'(edges), 64'd0);
        res = result_o;
        err = err_o;
    endtask

    task automatic consume();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, e, n);
        check("mul_res", 64'(r), 64'hFFFF_FFEB);
        check("mul_lat", 64'(n), 64'd33);
        check("mul_err", 64'(e), 64'd0);
        consume();
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, n);
        check("mulhu_res", 64'(r), 64'hFFFF_FFFE);
        consume();
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, r, e, n);
        check("mulhsu_res", 64'(r), 64'hFFFF_FFFF);
        consume();
        run_op(3'b001, 32'h8000_0000, 32'd2, r, e, n);
        check("mulh_res", 64'(r), 64'hFFFF_FFFF);
        consume();
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, e, n);
        check("mulh_pos", 64'(r), 64'd0);
        consume();

`ifdef MULDIV_DIV_EN
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, e, n);
        check("div_res", 64'(r), 64'hFFFF_FFFD);
        check("div_lat", 64'(n), 64'd33);
        consume();
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, e, n);
        check("rem_res", 64'(r), 64'hFFFF_FFFF);
        consume();
        run_op(3'b101, 32'd5, 32'd0, r, e, n);
        check("divz_res", 64'(r), 64'hFFFF_FFFF);
        check("divz_lat", 64'(n), 64'd1);
        consume();
        run_op(3'b111, 32'd5, 32'd0, r, e, n);
        check("remz_res", 64'(r), 64'd5);
        consume();
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, e, n);
        check("ovf_res", 64'(r), 64'h8000_0000);
        check("ovf_lat", 64'(n), 64'd1);
        consume();
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, e, n);
        check("ovf_rem", 64'(r), 64'd0);
        consume();
        run_op(3'b101, 32'd100, 32'd7, r, e, n);
        check("divu_res", 64'(r), 64'd14);
        consume();
        run_op(3'b111, 32'd100, 32'd7, r, e, n);
        check("remu_res", 64'(r), 64'd2);
        consume();
`else
        run_op(3'b101, 32'd9, 32'd3, r, e, n);
        check("nodiv_lat", 64'(n), 64'd1);
        check("nodiv_err", 64'(e), 64'd1);
        check("nodiv_res", 64'(r), 64'd0);
        consume();
        @(negedge clk_i);
        check("nodiv_err_clr", 64'(err_o), 64'd0);
`endif

        run_op(3'b000, 32'd3, 32'd5, r, e, n);
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; op_i = 3'b000; src1_i = 32'd9; src2_i = 32'd9;
            @(negedge clk_i);
            check("hold_res", 64'(result_o), 64'd15);
            check("hold_ready", 64'(ready_o), 64'd0);
            check("hold_valid", 64'(valid_o), 64'd1);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        @(negedge clk_i);
        check("cons_ready", 64'(ready_o), 64'd1);
        check("cons_valid", 64'(valid_o), 64'd0);
        check("cons_result", 64'(result_o), 64'd0);
        valid_i = 1'b0;

        @(negedge clk_i);
        valid_i = 1'b1; op_i = 3'b000; src1_i = 32'h1234_5678; src2_i = 32'h9ABC_DEF0;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) n++;
        end
        check("rst_mid_valid", 64'(n), 64'd0);
        check("rst_mid_ready", 64'(ready_o), 64'd1);
        run_op(3'b000, 32'd3, 32'd4, r, e, n);
        check("post_rst_res", 64'(r), 64'd12);
        check("post_rst_lat", 64'(n), 64'd33);
        consume();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
